// File: rtl/rs232c_pkg.sv
// Shared definitions for the RS-232C transmit path (and the matching receive side).
// Holds the serialiser state encoding, frame geometry constants and the default
// bit period in clock cycles.
package rs232c_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int FRAME_BITS = 10;  // start + 8 data + stop
  localparam int DATA_BITS  = 8;

  localparam logic [15:0] DEFAULT_WAIT_COUNT = 16'd2604;

endpackage

// File: rtl/rs232c_tx_sender_fifo.sv
// tx_fifo: circular byte buffer between the CPU strobe and the serialiser.
// Ports:
//   clk, reset (sync, active-low)
//   push, din  : write request and byte
//   pop        : read request (only honoured when not empty)
//   dout       : byte at the read pointer (valid while not empty)
//   full, empty: registered occupancy flags computed from the next count
// A push while full is accepted only if a pop frees a slot on the same edge.
module tx_fifo
  import rs232c_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic [DEPTH_LOG2:0]   count;
  logic [DEPTH_LOG2:0]   count_next;
  logic                  push_ok;
  logic                  pop_ok;

  always_comb begin
    pop_ok     = pop && !empty;
    push_ok    = push && (!full || pop_ok);
    count_next = count;
    if (push_ok && !pop_ok) begin
      count_next = count + CNT_ONE;
    end else if (pop_ok && !push_ok) begin
      count_next = count - CNT_ONE;
    end
  end

  assign dout = mem[rptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (push_ok) wptr <= wptr + PTR_ONE;
      if (pop_ok)  rptr <= rptr + PTR_ONE;
      count <= count_next;
      full  <= (count_next == FULL_COUNT);
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/rs232c_tx_sender.sv
// rs232c_tx_sender: buffers CPU bytes and serialises them as 8N1, LSB first.
// Ports:
//   clk                    : system clock
//   reset                  : sync, active-low
//   send_enable, send_data : push strobe and byte (one byte per asserted cycle)
//   tx                     : serial line, idle high, driven from a flop
//   fifo_full, fifo_empty  : buffer occupancy flags
//   busy                   : serialiser not idle (registered)
//   overflow               : sticky, set when a push is dropped; cleared by reset only
module rs232c_tx_sender
  import rs232c_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 4,
  parameter logic [15:0] WAIT_COUNT = DEFAULT_WAIT_COUNT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send_enable,
  input  logic [7:0] send_data,
  output logic       tx,
  output logic       fifo_full,
  output logic       fifo_empty,
  output logic       busy,
  output logic       overflow
);

  tx_state_t            state;
  tx_state_t            state_next;
  logic [15:0]          baud;
  logic [15:0]          baud_next;
  logic [2:0]           bit_idx;
  logic [2:0]           bit_idx_next;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] shift_next;
  logic [7:0]           fifo_dout;
  logic                 pop;
  logic                 bit_end;
  logic                 tx_next;

  tx_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (send_enable),
    .din   (send_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_next   = state;
    baud_next    = baud;
    bit_idx_next = bit_idx;
    shift_next   = shift;
    pop          = 1'b0;
    tx_next      = 1'b1;
    bit_end      = (baud == WAIT_COUNT - 16'd1);

    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_next = fifo_dout;
          state_next = START;
          baud_next  = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_next   = DATA;
          bit_idx_next = '0;
          baud_next    = '0;
        end else begin
          baud_next = baud + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_next  = '0;
          shift_next = shift >> 1;
          if (bit_idx == 3'(DATA_BITS - 1)) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end else begin
          baud_next = baud + 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_next = IDLE;
          baud_next  = '0;
        end else begin
          baud_next = baud + 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Line level is decided from the state being entered so tx comes straight off a flop.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      baud     <= '0;
      bit_idx  <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state   <= state_next;
      baud    <= baud_next;
      bit_idx <= bit_idx_next;
      tx      <= tx_next;
      busy    <= (state_next != IDLE);
      // A push while full is only lost when no pop frees a slot on this edge.
      if (send_enable && fifo_full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    shift <= shift_next;
  end

endmodule

// File: tb/tb_rs232c_tx_sender.sv
// Testbench for rs232c_tx_sender: a 4-entry buffer and a 4-cycle bit period,
// compared every cycle against a queue-and-frame-timer reference model.
module tb_rs232c_tx_sender;

  localparam int W     = 4;
  localparam int DL2   = 2;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       send_enable;
  logic [7:0] send_data;
  logic       tx;
  logic       fifo_full;
  logic       fifo_empty;
  logic       busy;
  logic       overflow;

  rs232c_tx_sender #(.DEPTH_LOG2(DL2), .WAIT_COUNT(16'(W))) dut (
    .clk         (clk),
    .reset       (reset),
    .send_enable (send_enable),
    .send_data   (send_data),
    .tx          (tx),
    .fifo_full   (fifo_full),
    .fifo_empty  (fifo_empty),
    .busy        (busy),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pending bytes, bytes sent so far, and the frame in flight.
  logic [7:0] q[$];
  logic [7:0] sent[$];
  bit         m_active = 1'b0;
  int         m_t = 0;
  logic [7:0] m_byte = 8'h00;
  bit         m_ovf = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Line level at cycle m_t of a frame: start bit, 8 data bits LSB first, stop bit.
  function automatic logic exp_tx();
    int k;
    if (!m_active) return 1'b1;
    k = m_t / W;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_byte[k-1];
    return 1'b1;
  endfunction

  task automatic model(input logic r, input logic en, input logic [7:0] d);
    if (!r) begin
      q.delete();
      m_active = 1'b0;
      m_t      = 0;
      m_ovf    = 1'b0;
      return;
    end
    if (m_active) begin
      m_t++;
      if (m_t == 10 * W) m_active = 1'b0;
    end else if (q.size() > 0) begin
      m_byte   = q.pop_front();
      sent.push_back(m_byte);
      m_active = 1'b1;
      m_t      = 0;
    end
    if (en) begin
      if (q.size() < DEPTH) q.push_back(d);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic step(input logic r, input logic en, input logic [7:0] d);
    reset       = r;
    send_enable = en;
    send_data   = d;
    @(posedge clk);
    model(r, en, d);
    #1;
    check("tx", 32'(tx), 32'(exp_tx()));
    check("busy", 32'(busy), 32'(m_active));
    check("fifo_empty", 32'(fifo_empty), 32'(q.size() == 0));
    check("fifo_full", 32'(fifo_full), 32'(q.size() == DEPTH));
    check("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00);
  endtask

  task automatic push(input logic [7:0] d);
    step(1'b1, 1'b1, d);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
  endtask

  task automatic drain();
    int g = 0;
    while ((m_active || q.size() > 0) && g < 2000) begin
      idle(1);
      g++;
    end
    check("drain_bound", 32'(g < 2000), 32'd1);
    idle(2);
  endtask

  task automatic check_sent(input string tag, input logic [7:0] exp_list[$]);
    check({tag, "_count"}, 32'(sent.size()), 32'(exp_list.size()));
    for (int i = 0; i < exp_list.size() && i < sent.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(sent[i]), 32'(exp_list[i]));
  endtask

  initial begin
    logic [7:0] exp_list[$];
    logic [7:0] b;
    int         g;
    int         pushed;

    reset       = 1'b0;
    send_enable = 1'b0;
    send_data   = 8'h00;

    // Reset, then a long idle stretch with the line high.
    do_reset();
    idle(100);

    // Single 8'hA5 frame.
    sent.delete();
    push(8'hA5);
    check("a5_empty_after_push", 32'(fifo_empty), 32'd0);
    idle(1);
    check("a5_start_low", 32'(tx), 32'd0);
    check("a5_empty_after_pop", 32'(fifo_empty), 32'd1);
    idle(45);
    exp_list = '{8'hA5};
    check_sent("a5", exp_list);

    // Three back-to-back frames.
    sent.delete();
    push(8'h00);
    push(8'hFF);
    push(8'h55);
    drain();
    exp_list = '{8'h00, 8'hFF, 8'h55};
    check_sent("burst3", exp_list);
    check("burst3_no_overflow", 32'(overflow), 32'd0);

    // Fill while busy, then one push too many.
    sent.delete();
    push(8'h81);
    idle(3);
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    check("ovf_full", 32'(fifo_full), 32'd1);
    push(8'h99);
    check("ovf_set", 32'(overflow), 32'd1);
    drain();
    check("ovf_sticky", 32'(overflow), 32'd1);
    exp_list = '{8'h81, 8'h11, 8'h22, 8'h33, 8'h44};
    check_sent("ovf", exp_list);

    // Push into a full buffer on the same edge as the pop.
    do_reset();
    sent.delete();
    push(8'hC1);
    push(8'hC2);
    push(8'hC3);
    push(8'hC4);
    push(8'hC5);
    g = 0;
    while (m_active && g < 100) begin
      idle(1);
      g++;
    end
    check("popwait_bound", 32'(g < 100), 32'd1);
    push(8'h3C);
    check("pop_push_full", 32'(fifo_full), 32'd1);
    check("pop_push_no_ovf", 32'(overflow), 32'd0);
    drain();
    exp_list = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'h3C};
    check_sent("pop_push", exp_list);

    // Pointer wrap: 20 random bytes with random pacing.
    sent.delete();
    exp_list.delete();
    pushed = 0;
    g = 0;
    while (pushed < 20 && g < 5000) begin
      if (q.size() < DEPTH && $urandom_range(0, 3) != 0) begin
        b = 8'($urandom);
        exp_list.push_back(b);
        push(b);
        pushed++;
      end else begin
        idle(1);
      end
      g++;
    end
    check("wrap_bound", 32'(g < 5000), 32'd1);
    drain();
    check_sent("wrap", exp_list);

    // Reset in the middle of data bit 3, then a clean frame.
    b = 8'($urandom);
    push(b);
    push(8'($urandom));
    g = 0;
    while (!(m_active && m_t == 4 * W + 1) && g < 100) begin
      idle(1);
      g++;
    end
    check("bit3_bound", 32'(g < 100), 32'd1);
    step(1'b0, 1'b0, 8'h00);
    check("midreset_tx", 32'(tx), 32'd1);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_empty", 32'(fifo_empty), 32'd1);
    idle(3);
    sent.delete();
    b = 8'($urandom);
    push(b);
    drain();
    exp_list = '{b};
    check_sent("after_reset", exp_list);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
